// File: rtl/pal_test_pattern.sv
// PAL test-pattern generator: SMPTE/full-field bars, luma ramp, crosshatch, flat field and a
// moving bar, with a fixed two-cycle pipeline from raster position/controls to y/u/v.
module pal_test_pattern #(
    parameter int DATA_WIDTH   = 9,
    parameter int H_START      = 17,
    parameter int BAR_WIDTH    = 103,
    parameter int V_SPLIT1     = 324,
    parameter int V_SPLIT2     = 363,
    parameter int GRID_SPACING = 32,
    parameter int MOVE_STEP    = 4
) (
    input  logic                         palClock,
    input  logic                         reset,
    input  logic [9:0]                   hPos,
    input  logic [9:0]                   vPos,
    input  logic                         blank,
    input  logic                         sync,
    input  logic                         burst,
    input  logic                         burstPhase,
    input  logic [2:0]                   mode,
    input  logic signed [DATA_WIDTH-1:0] fieldY,
    input  logic signed [DATA_WIDTH-1:0] fieldU,
    input  logic signed [DATA_WIDTH-1:0] fieldV,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic signed [DATA_WIDTH-1:0] u,
    output logic signed [DATA_WIDTH-1:0] v,
    output logic                         blankDelayed,
    output logic                         syncDelayed,
    output logic                         burstDelayed,
    output logic                         burstPhaseDelayed,
    output logic                         frameStart
);

    // Colours are carried at 12 bits internally and narrowed losslessly at the output.
    typedef struct packed {
        logic signed [11:0] cy;
        logic signed [11:0] cu;
        logic signed [11:0] cv;
    } yuv_t;

    localparam yuv_t C_BLACK    = '{12'sd0,    12'sd0,    12'sd0};
    localparam yuv_t C_WHITE    = '{12'sd235,  12'sd0,    12'sd0};
    localparam yuv_t C_YELLOW   = '{12'sd169, -12'sd83,   12'sd19};
    localparam yuv_t C_CYAN     = '{12'sd134,  12'sd28,  -12'sd117};
    localparam yuv_t C_GREEN    = '{12'sd112, -12'sd55,  -12'sd98};
    localparam yuv_t C_MAGENTA  = '{12'sd79,   12'sd55,   12'sd98};
    localparam yuv_t C_RED      = '{12'sd57,  -12'sd28,   12'sd117};
    localparam yuv_t C_BLUE     = '{12'sd22,   12'sd83,  -12'sd19};
    localparam yuv_t C_MINUS_U  = '{12'sd0,   -12'sd64,   12'sd0};
    localparam yuv_t C_PLUS_V   = '{12'sd0,    12'sd0,    12'sd64};
    localparam yuv_t C_PLUGE_LO = '{-12'sd10,  12'sd0,    12'sd0};
    localparam yuv_t C_PLUGE_HI = '{12'sd10,   12'sd0,    12'sd0};

    localparam logic [7:0]  GRID_LAST = 8'(GRID_SPACING - 1);
    localparam logic [11:0] BAR_LIMIT = 12'(H_START + 720);

    function automatic logic [2:0] bar_index(input logic [9:0] h);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 1; k <= 6; k++) begin
            idx = idx + {2'b00, (int'(h) >= H_START + k * BAR_WIDTH)};
        end
        return idx;
    endfunction

    function automatic yuv_t top_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_WHITE;
            3'd1:    return C_YELLOW;
            3'd2:    return C_CYAN;
            3'd3:    return C_GREEN;
            3'd4:    return C_MAGENTA;
            3'd5:    return C_RED;
            3'd6:    return C_BLUE;
            default: return C_BLACK;
        endcase
    endfunction

    // Castellation mirrors the bars in reverse with black between them.
    function automatic yuv_t castellation(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_BLUE;
            3'd2:    return C_MAGENTA;
            3'd4:    return C_CYAN;
            3'd6:    return C_WHITE;
            default: return C_BLACK;
        endcase
    endfunction

    // Bottom row: -U, white, +V, black, PLUGE low, PLUGE high, black, one per bar slot.
    function automatic yuv_t bottom_row(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_MINUS_U;
            3'd1:    return C_WHITE;
            3'd2:    return C_PLUS_V;
            3'd4:    return C_PLUGE_LO;
            3'd5:    return C_PLUGE_HI;
            default: return C_BLACK;
        endcase
    endfunction

    logic                         frame_edge_s;
    logic [2:0]                   mode_r, mode_cur_s;
    logic signed [DATA_WIDTH-1:0] field_y_r, field_u_r, field_v_r;
    logic signed [DATA_WIDTH-1:0] field_y_s, field_u_s, field_v_s;
    logic [11:0]                  bar_pos_r, bar_sum_s, bar_cur_s;
    logic [7:0]                   hgrid_r, hgrid_s, vgrid_r, vgrid_s;
    logic [2:0]                   bar_idx_s;
    logic [10:0]                  h_off_s;
    logic [9:0]                   ramp_s;
    logic [11:0]                  h_ext_s;
    yuv_t                         pix_s;
    yuv_t                         p1_pix_r;
    logic [3:0]                   p1_ctl_r;
    logic                         p1_fs_r;

    assign frame_edge_s = (hPos == 10'd0) && (vPos == 10'd0);

    // Frame-boundary sampling: new settings take effect on the boundary pixel itself.
    always_comb begin
        mode_cur_s = mode_r;
        field_y_s  = field_y_r;
        field_u_s  = field_u_r;
        field_v_s  = field_v_r;
        bar_sum_s  = bar_pos_r + 12'(MOVE_STEP);
        bar_cur_s  = bar_pos_r;
        if (frame_edge_s) begin
            mode_cur_s = mode;
            field_y_s  = fieldY;
            field_u_s  = fieldU;
            field_v_s  = fieldV;
            if (bar_sum_s >= BAR_LIMIT) begin
                bar_cur_s = 12'(H_START);
            end else begin
                bar_cur_s = bar_sum_s;
            end
        end else begin
            mode_cur_s = mode_r;
        end
    end

    // Grid counters as seen by the current pixel.
    always_comb begin
        hgrid_s = hgrid_r;
        vgrid_s = vgrid_r;
        if (hPos == 10'(H_START)) begin
            hgrid_s = 8'd0;
        end else if (hgrid_r == GRID_LAST) begin
            hgrid_s = 8'd0;
        end else begin
            hgrid_s = hgrid_r + 8'd1;
        end
        if (vPos == 10'd0) begin
            vgrid_s = 8'd0;
        end else if (hPos == 10'd0) begin
            vgrid_s = (vgrid_r == GRID_LAST) ? 8'd0 : vgrid_r + 8'd1;
        end else begin
            vgrid_s = vgrid_r;
        end
    end

    // Pattern selection for the current pixel.
    always_comb begin
        pix_s     = C_BLACK;
        bar_idx_s = bar_index(hPos);
        h_off_s   = {1'b0, hPos} - 11'(H_START);
        ramp_s    = 10'(h_off_s >> 1);
        h_ext_s   = {2'b00, hPos};
        case (mode_cur_s)
            3'd0, 3'd1: begin
                if ((mode_cur_s == 3'd1) || (vPos < 10'(V_SPLIT1))) begin
                    pix_s = top_colour(bar_idx_s);
                end else if (vPos < 10'(V_SPLIT2)) begin
                    pix_s = castellation(bar_idx_s);
                end else begin
                    pix_s = bottom_row(bar_idx_s);
                end
            end
            3'd2: begin
                if (hPos < 10'(H_START)) begin
                    pix_s = C_BLACK;
                end else if (ramp_s > 10'd255) begin
                    pix_s = '{12'sd255, 12'sd0, 12'sd0};
                end else begin
                    pix_s = '{{2'b00, ramp_s}, 12'sd0, 12'sd0};
                end
            end
            3'd3: begin
                if ((hgrid_s == 8'd0) || (vgrid_s == 8'd0)) begin
                    pix_s = C_WHITE;
                end else begin
                    pix_s = C_BLACK;
                end
            end
            3'd4: begin
                pix_s = '{12'(field_y_s), 12'(field_u_s), 12'(field_v_s)};
            end
            3'd5: begin
                if ((h_ext_s >= bar_cur_s) && (h_ext_s < bar_cur_s + 12'(BAR_WIDTH)) &&
                    (hPos != 10'h3FF)) begin
                    pix_s = C_WHITE;
                end else begin
                    pix_s = C_BLACK;
                end
            end
            default: pix_s = C_BLACK;
        endcase
    end

    // Sampled settings, bar position and grid counters.
    always_ff @(posedge palClock) begin
        if (reset) begin
            mode_r    <= 3'd0;
            field_y_r <= {DATA_WIDTH{1'b0}};
            field_u_r <= {DATA_WIDTH{1'b0}};
            field_v_r <= {DATA_WIDTH{1'b0}};
            bar_pos_r <= 12'(H_START);
            hgrid_r   <= 8'd0;
            vgrid_r   <= 8'd0;
        end else begin
            mode_r    <= mode_cur_s;
            field_y_r <= field_y_s;
            field_u_r <= field_u_s;
            field_v_r <= field_v_s;
            bar_pos_r <= bar_cur_s;
            hgrid_r   <= hgrid_s;
            vgrid_r   <= vgrid_s;
        end
    end

    // Two-stage output pipeline keeping pixels, controls and frameStart aligned.
    always_ff @(posedge palClock) begin
        if (reset) begin
            p1_pix_r          <= C_BLACK;
            p1_ctl_r          <= 4'b1000;
            p1_fs_r           <= 1'b0;
            y                 <= {DATA_WIDTH{1'b0}};
            u                 <= {DATA_WIDTH{1'b0}};
            v                 <= {DATA_WIDTH{1'b0}};
            blankDelayed      <= 1'b1;
            syncDelayed       <= 1'b0;
            burstDelayed      <= 1'b0;
            burstPhaseDelayed <= 1'b0;
            frameStart        <= 1'b0;
        end else begin
            p1_pix_r          <= pix_s;
            p1_ctl_r          <= {blank, sync, burst, burstPhase};
            p1_fs_r           <= frame_edge_s;
            y                 <= DATA_WIDTH'(p1_pix_r.cy);
            u                 <= DATA_WIDTH'(p1_pix_r.cu);
            v                 <= DATA_WIDTH'(p1_pix_r.cv);
            blankDelayed      <= p1_ctl_r[3];
            syncDelayed       <= p1_ctl_r[2];
            burstDelayed      <= p1_ctl_r[1];
            burstPhaseDelayed <= p1_ctl_r[0];
            frameStart        <= p1_fs_r;
        end
    end

endmodule

// File: tb/tb_pal_test_pattern.sv
// Self-checking bench for pal_test_pattern: default-width and 12-bit instances driven in
// parallel, checked against a behavioural pattern model plus constant vector tables.
module tb_pal_test_pattern;

    localparam int HS  = 17;
    localparam int BW  = 103;
    localparam int VS1 = 324;
    localparam int VS2 = 363;
    localparam int G   = 32;
    localparam int MS  = 4;

    typedef struct {
        bit       valid;
        bit       chk_y;
        int       y;
        int       u;
        int       v;
        bit [3:0] ctl;
        bit       fs;
    } exp_t;

    typedef struct {
        int md;
        int h;
        int vp;
        int ey;
        int eu;
        int ev;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [9:0] hPos, vPos;
    logic blank, sync, burst, burstPhase;
    logic [2:0] mode;
    logic signed [8:0]  fy9, fu9, fv9;
    logic signed [11:0] fy12, fu12, fv12;
    logic signed [8:0]  y9, u9, v9;
    logic signed [11:0] y12, u12, v12;
    logic bd9, sd9, bud9, bpd9, fs9;
    logic bd12, sd12, bud12, bpd12, fs12;

    int n_cmp = 0;
    int n_bad = 0;
    int fs_seen = 0;

    int m_mode, m_fy, m_fu, m_fv, m_bar;
    exp_t d1, d2;
    exp_t RST = '{1'b1, 1'b1, 0, 0, 0, 4'b1000, 1'b0};

    int top_c [7][3] = '{'{235, 0, 0}, '{169, -83, 19}, '{134, 28, -117}, '{112, -55, -98},
                         '{79, 55, 98}, '{57, -28, 117}, '{22, 83, -19}};
    int bot_c [7][3] = '{'{0, -64, 0}, '{235, 0, 0}, '{0, 0, 64}, '{0, 0, 0},
                         '{-10, 0, 0}, '{10, 0, 0}, '{0, 0, 0}};
    int cast_src [7] = '{6, -1, 4, -1, 2, -1, 0};
    int rand_modes [7] = '{0, 1, 2, 4, 5, 6, 7};
    vec_t tbl [17];

    always #5 clk = ~clk;

    pal_test_pattern dut9 (
        .palClock(clk), .reset(reset), .hPos(hPos), .vPos(vPos),
        .blank(blank), .sync(sync), .burst(burst), .burstPhase(burstPhase),
        .mode(mode), .fieldY(fy9), .fieldU(fu9), .fieldV(fv9),
        .y(y9), .u(u9), .v(v9),
        .blankDelayed(bd9), .syncDelayed(sd9), .burstDelayed(bud9),
        .burstPhaseDelayed(bpd9), .frameStart(fs9)
    );

    pal_test_pattern #(.DATA_WIDTH(12)) dut12 (
        .palClock(clk), .reset(reset), .hPos(hPos), .vPos(vPos),
        .blank(blank), .sync(sync), .burst(burst), .burstPhase(burstPhase),
        .mode(mode), .fieldY(fy12), .fieldU(fu12), .fieldV(fv12),
        .y(y12), .u(u12), .v(v12),
        .blankDelayed(bd12), .syncDelayed(sd12), .burstDelayed(bud12),
        .burstPhaseDelayed(bpd12), .frameStart(fs12)
    );

    function automatic exp_t model_pix(int md, int h, int vp);
        exp_t e;
        int   bi;
        e = '{1'b1, 1'b1, 0, 0, 0, 4'b0000, 1'b0};
        bi = (h < HS + BW) ? 0 : (h - HS) / BW;
        if (bi > 6) bi = 6;
        case (md)
            0, 1: begin
                if (md == 1 || vp < VS1) begin
                    e.y = top_c[bi][0]; e.u = top_c[bi][1]; e.v = top_c[bi][2];
                end else if (vp < VS2) begin
                    if (cast_src[bi] >= 0) begin
                        e.y = top_c[cast_src[bi]][0];
                        e.u = top_c[cast_src[bi]][1];
                        e.v = top_c[cast_src[bi]][2];
                    end
                end else begin
                    e.y = bot_c[bi][0]; e.u = bot_c[bi][1]; e.v = bot_c[bi][2];
                end
            end
            2: e.y = (h < HS) ? 0 : (((h - HS) / 2 > 255) ? 255 : (h - HS) / 2);
            3: begin
                e.y     = ((h >= HS && (h - HS) % G == 0) || vp % G == 0) ? 235 : 0;
                e.chk_y = (h >= HS) || (vp % G == 0);
            end
            4: begin
                e.y = m_fy; e.u = m_fu; e.v = m_fv;
            end
            5: e.y = (h >= m_bar && h < m_bar + BW && h < 1023) ? 235 : 0;
            default: e.y = 0;
        endcase
        return e;
    endfunction

    task automatic check_out(input exp_t e);
        bit ok9, ok12;
        if (e.valid) begin
            ok9 = (!e.chk_y || int'(y9) == e.y) && int'(u9) == e.u && int'(v9) == e.v &&
                  {bd9, sd9, bud9, bpd9} == e.ctl && fs9 == e.fs;
            ok12 = (!e.chk_y || int'(y12) == e.y) && int'(u12) == e.u && int'(v12) == e.v &&
                   {bd12, sd12, bud12, bpd12} == e.ctl && fs12 == e.fs;
            n_cmp += 2;
            if (!ok9) begin
                n_bad++;
                $display("FAIL pipe_dw9 t=%0t: got yuv=%0d/%0d/%0d ctl=%b fs=%b, want %0d/%0d/%0d ctl=%b fs=%b",
                         $time, y9, u9, v9, {bd9, sd9, bud9, bpd9}, fs9, e.y, e.u, e.v, e.ctl, e.fs);
            end
            if (!ok12) begin
                n_bad++;
                $display("FAIL pipe_dw12 t=%0t: got yuv=%0d/%0d/%0d ctl=%b fs=%b, want %0d/%0d/%0d ctl=%b fs=%b",
                         $time, y12, u12, v12, {bd12, sd12, bud12, bpd12}, fs12, e.y, e.u, e.v, e.ctl, e.fs);
            end
        end
    endtask

    task automatic step(input bit rst, input int h, input int vp, input int md,
                        input int fy, input int fu, input int fv, input bit [3:0] ctl);
        exp_t cur;
        bit   edge_pix;
        @(negedge clk);
        if (fs9 === 1'b1) fs_seen++;
        check_out(d2);
        d2 = d1;
        reset = rst; hPos = 10'(h); vPos = 10'(vp); mode = 3'(md);
        fy9 = 9'(fy); fu9 = 9'(fu); fv9 = 9'(fv);
        fy12 = 12'(fy); fu12 = 12'(fu); fv12 = 12'(fv);
        {blank, sync, burst, burstPhase} = ctl;
        if (rst) begin
            m_mode = 0; m_fy = 0; m_fu = 0; m_fv = 0; m_bar = HS;
            cur = RST;
            d2 = RST;
        end else begin
            edge_pix = (h == 0) && (vp == 0);
            if (edge_pix) begin
                m_mode = md; m_fy = fy; m_fu = fu; m_fv = fv;
                m_bar  = (m_bar + MS >= HS + 720) ? HS : m_bar + MS;
            end
            cur     = model_pix(m_mode, h, vp);
            cur.ctl = ctl;
            cur.fs  = edge_pix;
        end
        d1 = cur;
    endtask

    task automatic idle2();
        step(1'b0, 1, 1, 0, 0, 0, 0, 4'b0000);
        step(1'b0, 1, 1, 0, 0, 0, 0, 4'b0000);
    endtask

    task automatic check_pix(input string nm, input int ey, input int eu, input int ev);
        n_cmp += 2;
        if (int'(y9) != ey || int'(u9) != eu || int'(v9) != ev) begin
            n_bad++;
            $display("FAIL %s dw9: got %0d/%0d/%0d want %0d/%0d/%0d", nm, y9, u9, v9, ey, eu, ev);
        end
        if (int'(y12) != ey || int'(u12) != eu || int'(v12) != ev) begin
            n_bad++;
            $display("FAIL %s dw12: got %0d/%0d/%0d want %0d/%0d/%0d", nm, y12, u12, v12, ey, eu, ev);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    initial begin
        int expbar, fs_before, fy, fu, fv;
        d1 = '{1'b0, 1'b0, 0, 0, 0, 4'b0000, 1'b0};
        d2 = d1;
        tbl = '{'{0, 119, 100, 235, 0, 0},   '{0, 120, 100, 169, -83, 19},
                '{0, 700, 100, 22, 83, -19},  '{0, 634, 100, 57, -28, 117},
                '{0, 20, 340, 22, 83, -19},   '{0, 130, 340, 0, 0, 0},
                '{0, 240, 340, 79, 55, 98},   '{0, 20, 400, 0, -64, 0},
                '{0, 450, 400, -10, 0, 0},    '{0, 560, 400, 10, 0, 0},
                '{1, 250, 400, 134, 28, -117},'{2, 16, 50, 0, 0, 0},
                '{2, 19, 50, 1, 0, 0},        '{2, 527, 50, 255, 0, 0},
                '{2, 526, 50, 254, 0, 0},     '{6, 300, 100, 0, 0, 0},
                '{7, 300, 100, 0, 0, 0}};

        // Reset state
        repeat (3) step(1'b1, 5, 5, 4, 50, 50, 50, 4'b0111);
        check_pix("reset_yuv", 0, 0, 0);
        check_bit("reset_blank9", bd9, 1'b1);
        check_bit("reset_blank12", bd12, 1'b1);
        check_bit("reset_sync9", sd9, 1'b0);
        check_bit("reset_fs9", fs9, 1'b0);

        // Constant vectors, each preceded by a frame boundary selecting its mode
        foreach (tbl[i]) begin
            step(1'b0, 0, 0, tbl[i].md, 0, 0, 0, 4'b0000);
            step(1'b0, tbl[i].h, tbl[i].vp, tbl[i].md, 0, 0, 0, 4'b0000);
            idle2();
            check_pix($sformatf("vec%0d", i), tbl[i].ey, tbl[i].eu, tbl[i].ev);
        end

        // Blue v=-19 sign-extends to 0xFED at 12 bits
        step(1'b0, 0, 0, 0, 0, 0, 0, 4'b0000);
        step(1'b0, 700, 100, 0, 0, 0, 0, 4'b0000);
        idle2();
        n_cmp++;
        if (v12 !== 12'hFED) begin
            n_bad++;
            $display("FAIL blue_v_dw12: got %h want fed", v12);
        end

        // Mode/field changes ignored until the frame boundary
        step(1'b0, 0, 0, 0, 0, 0, 0, 4'b0000);
        for (int h = 40; h < 60; h++) step(1'b0, h, 200, 4, 50, -20, 30, 4'b0000);
        idle2();
        check_pix("mode_change_ignored", 235, 0, 0);
        step(1'b0, 0, 0, 4, 50, -20, 30, 4'b0000);
        step(1'b0, 300, 5, 0, 0, 0, 0, 4'b0000);
        idle2();
        check_pix("flat_field", 50, -20, 30);

        // Reset mid-line in mode 4 flushes the pipe and falls back to mode 0
        for (int h = 100; h < 110; h++) step(1'b0, h, 10, 4, 50, -20, 30, 4'b0100);
        step(1'b1, 110, 10, 4, 50, -20, 30, 4'b0100);
        step(1'b0, 111, 10, 4, 50, -20, 30, 4'b0100);
        check_pix("mid_reset_yuv", 0, 0, 0);
        check_bit("mid_reset_blank", bd9, 1'b1);
        step(1'b0, 60, 10, 4, 50, -20, 30, 4'b0000);
        idle2();
        check_pix("after_reset_mode0", 235, 0, 0);
        step(1'b0, 0, 0, 0, 0, 0, 0, 4'b0000);
        idle2();

        // Moving bar over 200 frames; bar start is a closed form of the frame count
        step(1'b1, 1, 1, 5, 0, 0, 0, 4'b0000);
        fs_before = fs_seen;
        for (int k = 1; k <= 200; k++) begin
            expbar = HS + MS * (k % 180);
            step(1'b0, 0, 0, 5, 0, 0, 0, 4'b0000);
            step(1'b0, expbar - 1, 5, 5, 0, 0, 0, 4'b0000);
            step(1'b0, expbar, 5, 5, 0, 0, 0, 4'b0000);
            idle2();
            n_cmp++;
            if (int'(y9) != 235) begin
                n_bad++;
                $display("FAIL bar_frame%0d: got y=%0d want 235 at hPos %0d", k, y9, expbar);
            end
        end
        idle2();
        n_cmp++;
        if (fs_seen - fs_before != 200) begin
            n_bad++;
            $display("FAIL frame_start_count: got %0d want 200", fs_seen - fs_before);
        end

        // Crosshatch over a sequential raster
        step(1'b0, 0, 0, 3, 0, 0, 0, 4'b0000);
        for (int h = 1; h <= 120; h++) step(1'b0, h, 0, 3, 0, 0, 0, 4'b0000);
        for (int vp = 1; vp <= 70; vp++)
            for (int h = 0; h <= 120; h++) step(1'b0, h, vp, 3, 0, 0, 0, 4'b0000);

        // Randomised frames with ignored mid-frame changes and occasional resets
        for (int f = 0; f < 30; f++) begin
            fy = int'($urandom_range(0, 511)) - 256;
            fu = int'($urandom_range(0, 511)) - 256;
            fv = int'($urandom_range(0, 511)) - 256;
            step(1'b0, 0, 0, rand_modes[$urandom_range(0, 6)], fy, fu, fv, 4'($urandom_range(0, 15)));
            for (int p = 0; p < 150; p++) begin
                step($urandom_range(0, 199) == 0, int'($urandom_range(0, 1023)),
                     int'($urandom_range(1, 1023)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                     int'($urandom_range(0, 511)) - 256, 4'($urandom_range(0, 15)));
            end
        end
        idle2();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
